// File: rtl/i2c_slave_write_receiver.sv
// I2C write-only responder: oversamples SCL/SDA on the system clock, detects
// START/STOP, answers SLAVE_ADDR with ACKs and turns each received data byte
// into a one-cycle register-write strobe with an auto-incrementing address.
//
// Handshake: reg_we is a one-cycle strobe with no back-pressure; reg_addr and
// reg_data are stable while reg_we is high, and reg_addr advances on the
// cycle after the strobe.
module i2c_slave_write_receiver #(
  parameter logic [6:0] SLAVE_ADDR = 7'h60
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       scl,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_data,
  output logic       reg_we,
  output logic       busy,
  output logic [7:0] rx_count,
  output logic [2:0] fsm_state
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ADDR     = 3'd1,
    ADDR_ACK = 3'd2,
    REG      = 3'd3,
    REG_ACK  = 3'd4,
    DATA     = 3'd5,
    DATA_ACK = 3'd6,
    IGNORE   = 3'd7
  } state_t;

  state_t     state;
  logic       scl_s1, scl_s2, scl_d;
  logic       sda_s1, sda_s2, sda_d;
  logic [2:0] bit_cnt;
  logic [6:0] shift;
  logic       ack_on;
  logic       we_pend;

  logic       scl_rise, scl_fall, start_det, stop_det;
  logic [7:0] byte_in;

  // SCL must be high in both the current and previous sample, so an SDA edge
  // coinciding with an SCL edge is never mistaken for START/STOP.
  assign scl_rise  = scl_s2 & ~scl_d;
  assign scl_fall  = ~scl_s2 & scl_d;
  assign start_det = scl_s2 & scl_d & sda_d & ~sda_s2;
  assign stop_det  = scl_s2 & scl_d & ~sda_d & sda_s2;
  assign byte_in   = {shift, sda_s2};
  assign fsm_state = state;

  // Two-flop synchronizers plus one history flop; reset to the idle bus level.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      scl_s1 <= 1'b1;
      scl_s2 <= 1'b1;
      scl_d  <= 1'b1;
      sda_s1 <= 1'b1;
      sda_s2 <= 1'b1;
      sda_d  <= 1'b1;
    end else begin
      scl_s1 <= scl;
      scl_s2 <= scl_s1;
      scl_d  <= scl_s2;
      sda_s1 <= sda_in;
      sda_s2 <= sda_s1;
      sda_d  <= sda_s2;
    end
  end

  // Protocol FSM, byte shifter, ACK driver and register-write strobe.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      bit_cnt  <= 3'd0;
      shift    <= 7'd0;
      ack_on   <= 1'b0;
      we_pend  <= 1'b0;
      sda_oe   <= 1'b0;
      reg_addr <= 8'd0;
      reg_data <= 8'd0;
      reg_we   <= 1'b0;
      busy     <= 1'b0;
      rx_count <= 8'd0;
    end else begin
      we_pend <= 1'b0;
      reg_we  <= we_pend;
      if (reg_we) reg_addr <= reg_addr + 8'd1;

      if (start_det) begin
        state    <= ADDR;
        bit_cnt  <= 3'd0;
        ack_on   <= 1'b0;
        sda_oe   <= 1'b0;
        busy     <= 1'b0;
        rx_count <= 8'd0;
      end else if (stop_det) begin
        state   <= IDLE;
        bit_cnt <= 3'd0;
        ack_on  <= 1'b0;
        sda_oe  <= 1'b0;
        busy    <= 1'b0;
      end else begin
        case (state)
          ADDR, REG, DATA: begin
            if (scl_rise) begin
              shift   <= byte_in[6:0];
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                bit_cnt <= 3'd0;
                if (state == ADDR) begin
                  if (byte_in == {SLAVE_ADDR, 1'b0}) begin
                    state <= ADDR_ACK;
                    busy  <= 1'b1;
                  end else begin
                    state <= IGNORE;
                  end
                end else if (state == REG) begin
                  reg_addr <= byte_in;
                  state    <= REG_ACK;
                end else begin
                  reg_data <= byte_in;
                  we_pend  <= 1'b1;
                  rx_count <= (rx_count == 8'hFF) ? rx_count : rx_count + 8'd1;
                  state    <= DATA_ACK;
                end
              end
            end
          end
          ADDR_ACK, REG_ACK, DATA_ACK: begin
            // First fall opens the ACK clock, second fall closes it.
            if (scl_fall) begin
              if (!ack_on) begin
                sda_oe <= 1'b1;
                ack_on <= 1'b1;
              end else begin
                sda_oe <= 1'b0;
                ack_on <= 1'b0;
                state  <= (state == ADDR_ACK) ? REG : DATA;
              end
            end
          end
          default: begin
            sda_oe <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_write_receiver.sv
// Bench for i2c_slave_write_receiver: a bit-banged I2C master drives the
// wired-AND bus, a monitor collects write strobes, and a transaction-level
// model predicts strobes, ACKs and the held output registers.
module tb_i2c_slave_write_receiver;

  localparam int Q = 5;  // quarter SCL period in system clocks

  logic       clock;
  logic       reset;
  logic       scl;
  logic       sda_m;
  logic       sda_in;
  logic       sda_oe;
  logic [7:0] reg_addr;
  logic [7:0] reg_data;
  logic       reg_we;
  logic       busy;
  logic [7:0] rx_count;
  logic [2:0] fsm_state;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] exp_q[$];
  logic [15:0] obs_q[$];
  logic [7:0]  tx_q[$];
  logic        oe_seen;
  logic        busy_seen;

  logic [7:0] m_reg_addr;
  logic [7:0] m_reg_data;
  logic [7:0] m_rx;

  assign sda_in = sda_m & ~sda_oe;

  i2c_slave_write_receiver dut (
    .clock     (clock),
    .reset     (reset),
    .scl       (scl),
    .sda_in    (sda_in),
    .sda_oe    (sda_oe),
    .reg_addr  (reg_addr),
    .reg_data  (reg_data),
    .reg_we    (reg_we),
    .busy      (busy),
    .rx_count  (rx_count),
    .fsm_state (fsm_state)
  );

  // clock / reset block
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #3ms;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  // monitor: sampled on the falling edge, away from the active edge
  always @(negedge clock) begin
    if (reg_we) obs_q.push_back({reg_addr, reg_data});
    if (sda_oe) oe_seen = 1'b1;
    if (busy) busy_seen = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // driver tasks
  task automatic bus_start();
    wait_clk(Q); sda_m = 1'b1;
    wait_clk(Q); scl = 1'b1;
    wait_clk(2*Q); sda_m = 1'b0;
    wait_clk(2*Q); scl = 1'b0;
  endtask

  task automatic bus_stop();
    wait_clk(Q); sda_m = 1'b0;
    wait_clk(Q); scl = 1'b1;
    wait_clk(2*Q); sda_m = 1'b1;
    wait_clk(2*Q);
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      wait_clk(Q); sda_m = b[i];
      wait_clk(Q); scl = 1'b1;
      wait_clk(2*Q); scl = 1'b0;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    send_bits(b, 8);
    wait_clk(Q); sda_m = 1'b1;
    wait_clk(Q); scl = 1'b1;
    wait_clk(Q); ack = sda_oe;
    wait_clk(Q); scl = 1'b0;
  endtask

  task automatic clear_mon();
    obs_q.delete();
    exp_q.delete();
    oe_seen = 1'b0;
    busy_seen = 1'b0;
  endtask

  // Reference model: one write transaction at byte level.
  task automatic model_txn();
    logic [7:0] r;
    int nd;
    if (tx_q[0] == 8'hC0 && tx_q.size() >= 2) begin
      r  = tx_q[1];
      nd = tx_q.size() - 2;
      for (int k = 2; k < tx_q.size(); k++) begin
        exp_q.push_back({r, tx_q[k]});
        m_reg_data = tx_q[k];
        r = r + 8'd1;
      end
      m_reg_addr = r;
      m_rx = (nd > 255) ? 8'hFF : 8'(nd);
    end else begin
      m_rx = 8'd0;
    end
  endtask

  task automatic compare_end(input string tag);
    check({tag, "_busy_end"}, 32'(busy), 32'd0);
    check({tag, "_state_end"}, 32'(fsm_state), 32'd0);
    check({tag, "_oe_end"}, 32'(sda_oe), 32'd0);
    check({tag, "_rx_count"}, 32'(rx_count), 32'(m_rx));
    check({tag, "_reg_addr"}, 32'(reg_addr), 32'(m_reg_addr));
    check({tag, "_reg_data"}, 32'(reg_data), 32'(m_reg_data));
    check({tag, "_n_writes"}, 32'(obs_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
      check({tag, "_write"}, 32'(obs_q[i]), 32'(exp_q[i]));
  endtask

  // Full transaction from tx_q; caller clears the monitor first.
  task automatic do_txn(input string tag);
    logic ack;
    logic matched;
    matched = (tx_q[0] == 8'hC0);
    model_txn();
    bus_start();
    for (int i = 0; i < tx_q.size(); i++) begin
      send_byte(tx_q[i], ack);
      check({tag, "_ack"}, 32'(ack), 32'(matched));
      if (i == 0) check({tag, "_busy_mid"}, 32'(busy), 32'(matched));
    end
    bus_stop();
    wait_clk(4);
    compare_end(tag);
    check({tag, "_oe_seen"}, 32'(oe_seen), 32'(matched));
    check({tag, "_busy_seen"}, 32'(busy_seen), 32'(matched));
  endtask

  initial begin
    logic ack;
    reset = 1'b0;
    scl   = 1'b1;
    sda_m = 1'b1;
    m_reg_addr = 8'd0;
    m_reg_data = 8'd0;
    m_rx = 8'd0;
    clear_mon();
    wait_clk(5);
    check("rst_oe", 32'(sda_oe), 32'd0);
    check("rst_we", 32'(reg_we), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_addr", 32'(reg_addr), 32'd0);
    check("rst_data", 32'(reg_data), 32'd0);
    check("rst_rx", 32'(rx_count), 32'd0);
    check("rst_state", 32'(fsm_state), 32'd0);
    reset = 1'b1;
    wait_clk(5);

    // basic single write
    clear_mon();
    tx_q = '{8'hC0, 8'h16, 8'hF0};
    do_txn("basic");

    // auto-increment with wrap
    clear_mon();
    tx_q = '{8'hC0, 8'hFE, 8'h11, 8'h22, 8'h33};
    do_txn("wrap");

    // wrong address and read bit
    clear_mon();
    tx_q = '{8'hC2, 8'h01, 8'h02, 8'h03};
    do_txn("addr61");
    clear_mon();
    tx_q = '{8'hC1, 8'h01, 8'h02, 8'h03};
    do_txn("read");

    // partial byte then repeated START
    clear_mon();
    bus_start();
    send_byte(8'hC0, ack); check("rs_ack0", 32'(ack), 32'd1);
    send_byte(8'h05, ack); check("rs_ack1", 32'(ack), 32'd1);
    m_reg_addr = 8'h05;
    send_bits(8'hA5, 4);
    tx_q = '{8'hC0, 8'h07, 8'hAA};
    do_txn("rstart");

    // reset during the ACK clock of the register byte
    clear_mon();
    bus_start();
    send_byte(8'hC0, ack); check("rr_ack0", 32'(ack), 32'd1);
    send_bits(8'h16, 8);
    wait_clk(Q); sda_m = 1'b1;
    wait_clk(Q); scl = 1'b1;
    wait_clk(Q);
    check("rr_ack_pre", 32'(sda_oe), 32'd1);
    reset = 1'b0;
    #1;
    check("rr_oe", 32'(sda_oe), 32'd0);
    check("rr_busy", 32'(busy), 32'd0);
    check("rr_addr", 32'(reg_addr), 32'd0);
    check("rr_data", 32'(reg_data), 32'd0);
    check("rr_rx", 32'(rx_count), 32'd0);
    check("rr_we", 32'(reg_we), 32'd0);
    check("rr_state", 32'(fsm_state), 32'd0);
    m_reg_addr = 8'd0;
    m_reg_data = 8'd0;
    m_rx = 8'd0;
    wait_clk(3);
    reset = 1'b1;
    wait_clk(Q); scl = 1'b0;
    bus_stop();
    clear_mon();
    tx_q = '{8'hC0, 8'h16, 8'hF5};
    do_txn("post_rst");

    // STOP after 5 data bits
    clear_mon();
    bus_start();
    send_byte(8'hC0, ack); check("ps_ack0", 32'(ack), 32'd1);
    send_byte(8'h30, ack); check("ps_ack1", 32'(ack), 32'd1);
    send_bits(8'h9C, 5);
    bus_stop();
    wait_clk(4);
    m_reg_addr = 8'h30;
    m_rx = 8'd0;
    compare_end("pstop");

    // randomized transactions
    for (int t = 0; t < 8; t++) begin
      int nd;
      clear_mon();
      tx_q.delete();
      tx_q.push_back(($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'hC0);
      tx_q.push_back(8'($urandom_range(0, 255)));
      nd = $urandom_range(1, 4);
      for (int k = 0; k < nd; k++) tx_q.push_back(8'($urandom));
      do_txn("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
